reg_file_sb: RTL and testbench
==============================

// Module: reg_file_sb
// PURPOSE
//  Parametrised register file with two write ports, optional same-cycle write->read bypass
//  and per-register scoreboard (pending) bits for the pipelined MIPS core.
//  Port 0 takes ALU write-back, port 1 takes load write-back; issue logic marks destinations
//  pending and reads back busy flags to detect RAW hazards. Entry 0 is hardwired to zero.
// PARAMETERS
//  DATA_WIDTH  32  register width in bits
//  ADDR_WIDTH  5   address width; depth = 2**ADDR_WIDTH entries
//  BYPASS      1   1: same-cycle write data forwarded to read ports; 0: reads return stored value
// PORTS
//  clk       in   1           clock; all state updates on rising edge
//  rst       in   1           synchronous, active-high reset
//  raddr1    in   ADDR_WIDTH  read port 1 address
//  raddr2    in   ADDR_WIDTH  read port 2 address
//  rdata1    out  DATA_WIDTH  read port 1 data (combinational)
//  rdata2    out  DATA_WIDTH  read port 2 data (combinational)
//  rbusy1    out  1           register at raddr1 has a pending producer (combinational)
//  rbusy2    out  1           register at raddr2 has a pending producer (combinational)
//  wen0      in   1           write enable, port 0 (ALU)
//  waddr0    in   ADDR_WIDTH  write address, port 0
//  wdata0    in   DATA_WIDTH  write data, port 0
//  wen1      in   1           write enable, port 1 (load)
//  waddr1    in   ADDR_WIDTH  write address, port 1
//  wdata1    in   DATA_WIDTH  write data, port 1
//  iss_en    in   1           mark iss_addr pending this cycle
//  iss_addr  in   ADDR_WIDTH  destination register of issuing instruction
//  busy_cnt  out  ADDR_WIDTH+1 registered count of pending registers
// BEHAVIOUR
//  - Reset (rst=1 at edge): every entry <= 0, every pending bit <= 0, busy_cnt <= 0; writes and
//    issues in that cycle ignored. Outputs after reset: rdataN=0, rbusyN=0, busy_cnt=0.
//  - Address 0: always reads 0, never bypassed, never pending; writes/issues to it are dropped.
//  - Writes commit at rising edge (latency 1 to stored value). Both ports same nonzero address
//    in one cycle: port 1 data wins; port 0 data discarded.
//  - Reads: rdataN = stored entry. With BYPASS=1 and a write hitting raddrN (nonzero) this
//    cycle, rdataN = that write's data (port 1 preferred over port 0). BYPASS=0: old value.
//  - Scoreboard: pending[a] set at edge when iss_en && a==iss_addr; cleared at edge when a
//    committed write (either port) hits a. Same-cycle issue and write to same address: set wins.
//    Write to a non-pending register is legal; issue to an already-pending register keeps it set.
//  - rbusyN = pending[raddrN] && !(BYPASS && write hits raddrN this cycle); 0 when raddrN==0.
//  - busy_cnt after each edge equals popcount(pending); width ADDR_WIDTH+1, never wraps
//    (max 2**ADDR_WIDTH-1). Same-cycle changes: net delta in {-2..+1}.
//  - Reset mid-operation: pending cleared regardless of in-flight issues/writes that cycle.
// TESTING
//  1. rst=1 one cycle -> all raddr reads give 0, rbusy 0, busy_cnt 0.
//  2. wen0,waddr0=5,wdata0=0xDEADBEEF; raddr1=5 same cycle -> BYPASS=1: rdata1=0xDEADBEEF
//     that cycle; BYPASS=0: old value, then 0xDEADBEEF next cycle.
//  3. wen0 & wen1 both addr 7, wdata0=0x11, wdata1=0x22 -> entry 7 = 0x22; bypass shows 0x22.
//  4. write 0xFFFFFFFF to addr 0 and iss_en addr 0 -> rdata 0, rbusy 0, busy_cnt unchanged.
//  5. iss 3, iss 4 (busy_cnt 2); then wen0 addr 3 + wen1 addr 4 same cycle -> busy_cnt 0,
//     rbusy for 3 drops to 0 in write cycle when BYPASS=1.
//  6. pending 9; iss_en 9 and wen1 addr 9 same cycle -> 9 stays pending, busy_cnt unchanged;
//     rst mid-sequence -> all cleared next cycle.

Source files
------------

// File: rtl/reg_file_sb.sv
// Two-write-port register file with optional write->read bypass and per-entry pending bits
// used by issue logic to detect RAW hazards. Entry 0 is hardwired to zero.
module reg_file_sb #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter bit BYPASS     = 1'b1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [ADDR_WIDTH-1:0] raddr1_i,
    input  logic [ADDR_WIDTH-1:0] raddr2_i,
    output logic [DATA_WIDTH-1:0] rdata1_o,
    output logic [DATA_WIDTH-1:0] rdata2_o,
    output logic                  rbusy1_o,
    output logic                  rbusy2_o,
    input  logic                  wen0_i,
    input  logic [ADDR_WIDTH-1:0] waddr0_i,
    input  logic [DATA_WIDTH-1:0] wdata0_i,
    input  logic                  wen1_i,
    input  logic [ADDR_WIDTH-1:0] waddr1_i,
    input  logic [DATA_WIDTH-1:0] wdata1_i,
    input  logic                  iss_en_i,
    input  logic [ADDR_WIDTH-1:0] iss_addr_i,
    output logic [ADDR_WIDTH:0]   busy_cnt_o
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0]      pending_q, pending_d;
    logic [ADDR_WIDTH:0]   busy_cnt_q, busy_cnt_d;

    logic w0_act, w1_act, iss_act;
    logic w0_hit1, w1_hit1, w0_hit2, w1_hit2;

    // Accesses aimed at entry 0 are dropped everywhere, so qualify them once here.
    assign w0_act  = wen0_i   && (waddr0_i   != '0);
    assign w1_act  = wen1_i   && (waddr1_i   != '0);
    assign iss_act = iss_en_i && (iss_addr_i != '0);

    assign w0_hit1 = BYPASS && w0_act && (waddr0_i == raddr1_i);
    assign w1_hit1 = BYPASS && w1_act && (waddr1_i == raddr1_i);
    assign w0_hit2 = BYPASS && w0_act && (waddr0_i == raddr2_i);
    assign w1_hit2 = BYPASS && w1_act && (waddr1_i == raddr2_i);

    always_comb begin
        rdata1_o = mem_q[raddr1_i];
        if (raddr1_i == '0) rdata1_o = '0;
        else if (w1_hit1)   rdata1_o = wdata1_i;
        else if (w0_hit1)   rdata1_o = wdata0_i;
    end

    always_comb begin
        rdata2_o = mem_q[raddr2_i];
        if (raddr2_i == '0) rdata2_o = '0;
        else if (w1_hit2)   rdata2_o = wdata1_i;
        else if (w0_hit2)   rdata2_o = wdata0_i;
    end

    // Hit signals already exclude address 0, and pending[0] is never set.
    assign rbusy1_o = pending_q[raddr1_i] && !(w0_hit1 || w1_hit1);
    assign rbusy2_o = pending_q[raddr2_i] && !(w0_hit2 || w1_hit2);

    // Writes clear first, then an issue to the same entry re-sets it.
    always_comb begin
        pending_d = pending_q;
        if (w0_act)  pending_d[waddr0_i] = 1'b0;
        if (w1_act)  pending_d[waddr1_i] = 1'b0;
        if (iss_act) pending_d[iss_addr_i] = 1'b1;
        pending_d[0] = 1'b0;
    end

    always_comb begin
        busy_cnt_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            busy_cnt_d = busy_cnt_d + {{ADDR_WIDTH{1'b0}}, pending_d[i]};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pending_q  <= '0;
            busy_cnt_q <= '0;
        end else begin
            pending_q  <= pending_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    // Port 1 is assigned last so it wins a same-address collision.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            if (w0_act) mem_q[waddr0_i] <= wdata0_i;
            if (w1_act) mem_q[waddr1_i] <= wdata1_i;
        end
    end

    assign busy_cnt_o = busy_cnt_q;

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: one bypassing and one non-bypassing instance share all
// inputs, and each vector is compared against hand-computed values.
module tb_reg_file_sb;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk;
    logic          rst;
    logic [AW-1:0] raddr1, raddr2, waddr0, waddr1, iss_addr;
    logic [DW-1:0] wdata0, wdata1;
    logic          wen0, wen1, iss_en;

    logic [DW-1:0] b_rdata1, b_rdata2, n_rdata1, n_rdata2;
    logic          b_rbusy1, b_rbusy2, n_rbusy1, n_rbusy2;
    logic [AW:0]   b_cnt, n_cnt;

    int checks = 0;
    int errors = 0;

    reg_file_sb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYPASS(1'b1)) dut (
        .clk_i(clk), .rst_i(rst),
        .raddr1_i(raddr1), .raddr2_i(raddr2),
        .rdata1_o(b_rdata1), .rdata2_o(b_rdata2),
        .rbusy1_o(b_rbusy1), .rbusy2_o(b_rbusy2),
        .wen0_i(wen0), .waddr0_i(waddr0), .wdata0_i(wdata0),
        .wen1_i(wen1), .waddr1_i(waddr1), .wdata1_i(wdata1),
        .iss_en_i(iss_en), .iss_addr_i(iss_addr),
        .busy_cnt_o(b_cnt)
    );

    reg_file_sb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYPASS(1'b0)) dut_nb (
        .clk_i(clk), .rst_i(rst),
        .raddr1_i(raddr1), .raddr2_i(raddr2),
        .rdata1_o(n_rdata1), .rdata2_o(n_rdata2),
        .rbusy1_o(n_rbusy1), .rbusy2_o(n_rbusy2),
        .wen0_i(wen0), .waddr0_i(waddr0), .wdata0_i(wdata0),
        .wen1_i(wen1), .waddr1_i(waddr1), .wdata1_i(wdata1),
        .iss_en_i(iss_en), .iss_addr_i(iss_addr),
        .busy_cnt_o(n_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change and outputs are sampled mid-cycle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst    = 1'b0;
        wen0   = 1'b0; waddr0 = '0; wdata0 = '0;
        wen1   = 1'b0; waddr1 = '0; wdata1 = '0;
        iss_en = 1'b0; iss_addr = '0;
    endtask

    initial begin
        idle();
        raddr1 = 5'd5;
        raddr2 = 5'd31;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("rst_rdata1", b_rdata1, 0);
        check("rst_rdata2", b_rdata2, 0);
        check("rst_rbusy1", 32'(b_rbusy1), 0);
        check("rst_cnt", 32'(b_cnt), 0);
        check("rst_cnt_nb", 32'(n_cnt), 0);

        // Write to 5 read back in the same cycle.
        wen0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'hDEADBEEF;
        #1;
        check("byp_rdata1", b_rdata1, 32'hDEADBEEF);
        check("nobyp_old", n_rdata1, 0);
        tick();
        idle();
        #1;
        check("stored_byp", b_rdata1, 32'hDEADBEEF);
        check("stored_nb", n_rdata1, 32'hDEADBEEF);

        // Both ports hit 7: port 1 wins.
        wen0 = 1'b1; waddr0 = 5'd7; wdata0 = 32'h11;
        wen1 = 1'b1; waddr1 = 5'd7; wdata1 = 32'h22;
        raddr2 = 5'd7;
        #1;
        check("coll_byp", b_rdata2, 32'h22);
        check("coll_nb_old", n_rdata2, 0);
        tick();
        idle();
        #1;
        check("coll_stored", b_rdata2, 32'h22);
        check("coll_stored_nb", n_rdata2, 32'h22);

        // Entry 0 ignores writes and issues.
        wen0 = 1'b1; waddr0 = 5'd0; wdata0 = 32'hFFFFFFFF;
        iss_en = 1'b1; iss_addr = 5'd0;
        raddr1 = 5'd0;
        #1;
        check("z_rdata_byp", b_rdata1, 0);
        check("z_rbusy", 32'(b_rbusy1), 0);
        tick();
        idle();
        #1;
        check("z_rdata_after", b_rdata1, 0);
        check("z_rdata_nb", n_rdata1, 0);
        check("z_cnt", 32'(b_cnt), 0);
        check("z_rbusy_after", 32'(b_rbusy1), 0);

        // Issue 3 then 4, then retire both in one cycle.
        raddr1 = 5'd3; raddr2 = 5'd4;
        iss_en = 1'b1; iss_addr = 5'd3;
        tick();
        idle();
        #1;
        check("iss3_cnt", 32'(b_cnt), 1);
        check("iss3_busy", 32'(b_rbusy1), 1);
        check("iss3_not4", 32'(b_rbusy2), 0);
        iss_en = 1'b1; iss_addr = 5'd4;
        tick();
        idle();
        #1;
        check("iss4_cnt", 32'(b_cnt), 2);
        check("iss4_busy", 32'(n_rbusy2), 1);
        wen0 = 1'b1; waddr0 = 5'd3; wdata0 = 32'h33;
        wen1 = 1'b1; waddr1 = 5'd4; wdata1 = 32'h44;
        #1;
        check("wb_rbusy1_byp", 32'(b_rbusy1), 0);
        check("wb_rbusy2_byp", 32'(b_rbusy2), 0);
        check("wb_rbusy1_nb", 32'(n_rbusy1), 1);
        check("wb_rdata2_byp", b_rdata2, 32'h44);
        check("wb_cnt_before", 32'(b_cnt), 2);
        tick();
        idle();
        #1;
        check("wb_cnt", 32'(b_cnt), 0);
        check("wb_cnt_nb", 32'(n_cnt), 0);
        check("wb_rbusy1_nb_after", 32'(n_rbusy1), 0);
        check("wb_rdata1", n_rdata1, 32'h33);

        // Issue and write to 9 in the same cycle: pending stays set.
        raddr1 = 5'd9; raddr2 = 5'd10;
        iss_en = 1'b1; iss_addr = 5'd9;
        tick();
        idle();
        #1;
        check("p9_cnt", 32'(b_cnt), 1);
        iss_en = 1'b1; iss_addr = 5'd9;
        wen1 = 1'b1; waddr1 = 5'd9; wdata1 = 32'h99;
        #1;
        check("p9_rbusy_byp", 32'(b_rbusy1), 0);
        check("p9_rbusy_nb", 32'(n_rbusy1), 1);
        tick();
        idle();
        #1;
        check("p9_cnt_after", 32'(b_cnt), 1);
        check("p9_rbusy_after", 32'(b_rbusy1), 1);
        check("p9_rdata", b_rdata1, 32'h99);
        iss_en = 1'b1; iss_addr = 5'd10;
        wen0 = 1'b1; waddr0 = 5'd12; wdata0 = 32'h12;
        tick();
        idle();
        #1;
        check("p10_cnt", 32'(b_cnt), 2);
        check("p10_rbusy2", 32'(b_rbusy2), 1);

        // Reset with an issue and writes in flight clears everything.
        rst = 1'b1;
        iss_en = 1'b1; iss_addr = 5'd11;
        wen0 = 1'b1; waddr0 = 5'd9; wdata0 = 32'hABCD;
        tick();
        idle();
        #1;
        check("mrst_cnt", 32'(b_cnt), 0);
        check("mrst_rbusy1", 32'(b_rbusy1), 0);
        check("mrst_rbusy2", 32'(b_rbusy2), 0);
        check("mrst_rdata1", b_rdata1, 0);
        raddr1 = 5'd11; raddr2 = 5'd12;
        #1;
        check("mrst_rbusy11", 32'(b_rbusy1), 0);
        check("mrst_rdata12", n_rdata2, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
